// File: rtl/alu_arbiter_if.sv
// Bundle of requester, ALU and response signals between the operation sources,
// the shared ALU and alu_arbiter. The arbiter uses the slave modport.
interface alu_arbiter_if;
  logic       rq0_valid;
  logic [7:0] rq0_a;
  logic [7:0] rq0_b;
  logic [2:0] rq0_imm;
  logic       rq0_op;
  logic       rq0_ready;

  logic       rq1_valid;
  logic [7:0] rq1_a;
  logic [7:0] rq1_b;
  logic [2:0] rq1_imm;
  logic       rq1_op;
  logic       rq1_ready;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_imm;
  logic       alu_opcode;
  logic [7:0] alu_result;

  logic       rsp_valid;
  logic       rsp_id;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic       busy;

  modport slave (
    input  rq0_valid, rq0_a, rq0_b, rq0_imm, rq0_op,
    output rq0_ready,
    input  rq1_valid, rq1_a, rq1_b, rq1_imm, rq1_op,
    output rq1_ready,
    output alu_a, alu_b, alu_imm, alu_opcode,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready,
    output busy
  );

  modport master (
    output rq0_valid, rq0_a, rq0_b, rq0_imm, rq0_op,
    input  rq0_ready,
    output rq1_valid, rq1_a, rq1_b, rq1_imm, rq1_op,
    input  rq1_ready,
    input  alu_a, alu_b, alu_imm, alu_opcode,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer in front of a registered one-cycle ALU.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module alu_arbiter (
  input  logic         sysclk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t state;
  state_t next_state;
  logic   last_grant;
  logic   grant_id;
  logic   accept;

  always_comb begin
    // NOTE: default every combinational output first so no path infers a latch.
    grant_id = 1'b0;
    if (bus.rq0_valid && bus.rq1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_id = 1'b0;
`else
      grant_id = ~last_grant;
`endif
    end else if (bus.rq1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign accept = (state == IDLE) && (bus.rq0_valid || bus.rq1_valid);

  always_ff @(posedge sysclk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = EXEC;
      EXEC:    next_state = WAIT;
      WAIT:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rq0_ready = 1'b0;
    bus.rq1_ready = 1'b0;
    bus.busy      = (state != IDLE);
    if (state == IDLE) begin
      bus.rq0_ready = bus.rq0_valid && !grant_id;
      bus.rq1_ready = bus.rq1_valid &&  grant_id;
    end
  end

  // The ALU samples alu_* on the EXEC->WAIT edge; its result is valid in WAIT.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      bus.alu_a      <= '0;
      bus.alu_b      <= '0;
      bus.alu_imm    <= '0;
      bus.alu_opcode <= 1'b0;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_id     <= 1'b0;
      bus.rsp_data   <= '0;
      last_grant     <= 1'b1;
    end else begin
      if (accept) begin
        bus.alu_a      <= grant_id ? bus.rq1_a   : bus.rq0_a;
        bus.alu_b      <= grant_id ? bus.rq1_b   : bus.rq0_b;
        bus.alu_imm    <= grant_id ? bus.rq1_imm : bus.rq0_imm;
        bus.alu_opcode <= grant_id ? bus.rq1_op  : bus.rq0_op;
        bus.rsp_id     <= grant_id;
        last_grant     <= grant_id;
      end
      if (state == WAIT) begin
        bus.rsp_data  <= bus.alu_result;
        bus.rsp_valid <= 1'b1;
      end else if (state == RESP && bus.rsp_ready) begin
        bus.rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single registered 8-bit ALU (add / shift-left-by-imm) between two requesters. It accepts one operation at a time, drives the ALU operand and opcode inputs, waits out the ALU's one-cycle registered latency, and returns the captured result with a tag identifying the requester. It sits between the two operation sources and the ALU instance.

## Interface
Parameters:
- none

Ports:
- sysclk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- rq0_valid  in  1  requester 0 has an operation pending
- rq0_a, rq0_b  in  8 each  requester 0 operands
- rq0_imm  in  3  requester 0 shift amount
- rq0_op  in  1  requester 0 opcode: 1 = add, 0 = b << imm
- rq0_ready  out  1  requester 0 operation accepted this cycle
- rq1_valid, rq1_a, rq1_b, rq1_imm, rq1_op, rq1_ready  same as requester 0, for requester 1
- alu_a, alu_b  out  8 each  operands to the ALU
- alu_imm  out  3  shift amount to the ALU
- alu_opcode  out  1  opcode to the ALU
- alu_result  in  8  registered ALU result
- rsp_valid  out  1  response available
- rsp_id  out  1  requester that issued the response operation
- rsp_data  out  8  ALU result
- rsp_ready  in  1  response consumer accepts
- busy  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, EXEC, WAIT, RESP.
- IDLE: a grant is computed combinationally from rqN_valid. rqN_ready = (state == IDLE) && grant to N. An accept occurs when valid && ready are both high at an edge.
- On accept: the winner's a/b/imm/op are registered into alu_* outputs, rsp_id <= winner, last_grant <= winner, and the FSM goes to EXEC.
- EXEC -> WAIT unconditionally. The ALU samples alu_* at this edge.
- WAIT -> RESP unconditionally. rsp_data <= alu_result and rsp_valid <= 1.
- RESP: rsp_valid, rsp_id and rsp_data are held stable until rsp_ready is high at an edge. At that edge rsp_valid <= 0 and the FSM goes to IDLE. No new accept occurs in that same cycle.
- Round-robin arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the requester that is not last_grant wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
- Requester rules:
  - A requester must hold its valid and fields stable until ready.
  - A requester may deassert valid before ready (withdrawal). This is legal and has no effect.
- The arbiter performs no arithmetic. Results are whatever the ALU produces: add wraps mod 256; shift discards bits shifted past bit 7.
- alu_* outputs hold the last issued operation until the next accept.

## Timing
- Reset values:
  - Outputs: rq0_ready = rq1_ready = 0 (state IDLE and no valid), alu_a = alu_b = 0, alu_imm = 0, alu_opcode = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, busy = 0.
  - Internal: state = IDLE, last_grant = 1.
- Latency: accept at edge E0; rsp_valid rises after edge E2 (visible in cycle E2..E3), i.e. 3 edges from accept to response.
- Minimum issue interval: 4 cycles per operation, with rsp_ready held high.
- rqN_ready is combinational from valid and state. It is never high outside IDLE, and never high for both requesters at once.
- Reset mid-operation: the in-flight operation is discarded, no response is issued, and all outputs return to their reset values immediately (asynchronous).
- rsp_ready high while rsp_valid is low is ignored.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: fixed priority. Requester 0 always wins when both are valid. last_grant is still recorded but does not affect arbitration.
- ALU_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single add: rq0 valid, a = 8'h0F, b = 8'h01, op = 1 -> rq0_ready in same cycle; rsp_valid 3 edges later with rsp_data = 8'h10, rsp_id = 0; busy high from accept until the RESP handshake.
- Shift and wrap: rq1 op = 0, b = 8'hC3, imm = 3 -> rsp_data = 8'h18, rsp_id = 1. Add of a = 8'hFF, b = 8'h02 -> 8'h01.
- Tie after reset: both valid with distinct operands, held -> rq0 accepted first, then rq1. With both continuously valid, ids alternate 0,1,0,1. Under ALU_ARB_FIXED_PRIO_EN the ids are 0,0,0,0.
- Backpressure: hold rsp_ready low 5 cycles in RESP -> rsp_valid/rsp_id/rsp_data stable and both readys low; raise rsp_ready -> IDLE next cycle, next accept one cycle later.
- Reset in EXEC or WAIT: assert reset -> all outputs go to reset values asynchronously; no rsp_valid after release; next tie is granted to rq0.
- Withdrawal: rq1 valid for one cycle while busy, then deasserted before IDLE -> no accept, no response for rq1.
